// File: rtl/hermes_local_arbiter.sv
// Packet-level round-robin arbiter that shares one Hermes LOCAL input port among NSRC sources.
// state   | meaning
// IDLE    | no owner; arbitrate among requesting sources
// HEADER  | owner granted; waiting for header flit
// SIZE    | waiting for size flit; loads payload counter
// PAYLOAD | forwarding payload until the counter hits terminal count
module hermes_local_arbiter #(
  parameter int NSRC      = 4,
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NSRC-1:0]      src_rx_i,
  input  logic [FLIT_SIZE-1:0] src_data_i [NSRC],
  output logic [NSRC-1:0]      src_credit_o,
  output logic                 rx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic [NSRC-1:0]      grant_o,
  output logic                 busy_o
);

  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_SIZE    = 2'd2;
  localparam logic [1:0] S_PAYLOAD = 2'd3;

  localparam logic [SEL_W-1:0]     PTR_RST = SEL_W'(NSRC - 1);
  localparam logic [FLIT_SIZE-1:0] CNT_ONE = FLIT_SIZE'(1);

  logic [1:0]           state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     ptr_q;
  logic [FLIT_SIZE-1:0] cnt_q;

  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] cand;
  logic             found;
  logic             xfer;

  // Rotating priority: first requester strictly after the last-served source.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NSRC; i++) begin
      cand = SEL_W'((int'(ptr_q) + i) % NSRC);
      if (!found && src_rx_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign rx_o   = busy_o & src_rx_i[sel_q];
  assign data_o = busy_o ? src_data_i[sel_q] : '0;
  assign xfer   = rx_o & credit_i;

  always_comb begin
    src_credit_o = '0;
    grant_o      = '0;
    if (busy_o) begin
      grant_o[sel_q]      = 1'b1;
      src_credit_o[sel_q] = credit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            sel_q   <= pick;
            ptr_q   <= pick;
            state_q <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (xfer) state_q <= S_SIZE;
        end
        S_SIZE: begin
          if (xfer) begin
            cnt_q   <= data_o;
            state_q <= (data_o == '0) ? S_IDLE : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // Terminal-count compare before decrement, so an all-ones size never wraps.
          if (xfer) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_local_arbiter.sv
// Self-checking bench for hermes_local_arbiter: directed vector table, corner sequences,
// and randomized packet traffic against a packet-level reference model.
module tb_hermes_local_arbiter;

  localparam int NSRC = 4;
  localparam int FW   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSRC-1:0] src_rx;
  logic [FW-1:0]   src_data [NSRC];
  logic [NSRC-1:0] src_credit;
  logic            rx_w;
  logic [FW-1:0]   data_w;
  logic            credit;
  logic [NSRC-1:0] grant;
  logic            busy;

  hermes_local_arbiter #(.NSRC(NSRC), .FLIT_SIZE(FW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_rx_i    (src_rx),
    .src_data_i  (src_data),
    .src_credit_o(src_credit),
    .rx_o        (rx_w),
    .data_o      (data_w),
    .credit_i    (credit),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NSRC-1:0] rx;
    logic [FW-1:0]   d;
    logic            cr;
    logic            erx;
    logic [FW-1:0]   ed;
    logic [NSRC-1:0] ecr;
    logic [NSRC-1:0] eg;
    logic            eb;
  } vec_t;

  vec_t tv[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: owner (-1 = none), last served, flits done and packet length.
  int     m_owner;
  int     m_last;
  longint m_k;
  longint m_total;

  logic [FW-1:0] pq [NSRC][$];
  int sent      [NSRC];
  int gap_after [NSRC];
  int gap_len   [NSRC];
  int drop_pct;
  int cred_mode;

  int   got_cnt;
  int   busy_norx;
  int   grants[$];
  logic prev_busy;
  int   last0_cyc;
  int   first3_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NSRC-1:0] g);
    if ($countones(g) != 1) return 99;
    for (int i = 0; i < NSRC; i++) if (g[i]) return i;
    return 99;
  endfunction

  function automatic bit all_empty();
    for (int s = 0; s < NSRC; s++) if (pq[s].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add(input logic [NSRC-1:0] rx, input logic [FW-1:0] d, input logic cr,
                     input logic erx, input logic [FW-1:0] ed, input logic [NSRC-1:0] ecr,
                     input logic [NSRC-1:0] eg, input logic eb);
    vec_t v;
    v.rx = rx; v.d = d; v.cr = cr; v.erx = erx; v.ed = ed; v.ecr = ecr; v.eg = eg; v.eb = eb;
    tv.push_back(v);
  endtask

  task automatic push_pkt(input int s, input int size);
    pq[s].push_back({8'(s), 8'hC0, 16'($urandom_range(16'hFFFF))});
    pq[s].push_back(FW'(size));
    for (int p = 0; p < size; p++) pq[s].push_back($urandom);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    src_rx = '0;
    credit = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      src_data[s]  = '0;
      pq[s].delete();
      sent[s]      = 0;
      gap_after[s] = 0;
      gap_len[s]   = 0;
    end
    m_owner = -1; m_last = NSRC - 1; m_k = 0; m_total = -1;
    drop_pct = 0; cred_mode = 0;
    got_cnt = 0; busy_norx = 0; grants.delete(); prev_busy = 1'b0;
    last0_cyc = -1; first3_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {rx_w, grant, src_credit, busy, data_w}, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic drive();
    for (int s = 0; s < NSRC; s++) begin
      logic hold;
      hold = 1'b0;
      if (gap_len[s] > 0 && sent[s] == gap_after[s]) begin
        hold = 1'b1;
        gap_len[s]--;
      end else if (drop_pct > 0 && int'($urandom_range(99)) < drop_pct) begin
        hold = 1'b1;
      end
      src_rx[s]   = (pq[s].size() > 0) && !hold;
      src_data[s] = (pq[s].size() > 0) ? pq[s][0] : (32'hBAD0_0000 | 32'(s));
    end
    credit = (cred_mode == 0) ? 1'b1 : (int'($urandom_range(99)) < 70);
  endtask

  task automatic model_step();
    int o;
    o = m_owner;
    if (o < 0) begin
      for (int i = 1; i <= NSRC; i++) begin
        int c;
        c = (m_last + i) % NSRC;
        if (src_rx[c]) begin
          m_owner = c; m_last = c; m_k = 0; m_total = -1;
          break;
        end
      end
    end else if (src_rx[o] && credit) begin
      if (m_k == 1) m_total = longint'(src_data[o]) + 2;
      m_k++;
      if (m_k == m_total) m_owner = -1;
      void'(pq[o].pop_front());
      sent[o]++;
    end
  endtask

  task automatic cycle();
    logic            erx, eb;
    logic [FW-1:0]   ed;
    logic [NSRC-1:0] ecr, eg;
    drive();
    @(negedge clk);
    cyc++;
    erx = 1'b0; eb = 1'b0; ed = '0; ecr = '0; eg = '0;
    if (m_owner >= 0) begin
      erx = src_rx[m_owner];
      ed  = src_data[m_owner];
      ecr[m_owner] = credit;
      eg[m_owner]  = 1'b1;
      eb  = 1'b1;
    end
    check($sformatf("outs_c%0d", cyc), {rx_w, grant, src_credit, busy, data_w}, {erx, eg, ecr, eb, ed});
    if (rx_w && credit) got_cnt++;
    if (busy && !rx_w) busy_norx++;
    if (busy && !prev_busy) grants.push_back(onehot_idx(grant));
    if (grant == 4'b0001 && rx_w && credit) last0_cyc = cyc;
    if (grant == 4'b1000 && first3_cyc < 0) first3_cyc = cyc;
    prev_busy = busy;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && m_owner < 0 && !busy)) begin
      cycle();
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 64'h1);
    repeat (2) cycle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rxrun, bp_x, n, total, sz;

    // Single source (src 2, size 3) then a size-4 packet under alternating credit.
    add(4'b0100, 32'h0101, 1, 0, 32'h0,    4'b0000, 4'b0000, 0);
    add(4'b0100, 32'h0101, 1, 1, 32'h0101, 4'b0100, 4'b0100, 1);
    add(4'b0100, 32'h3,    1, 1, 32'h3,    4'b0100, 4'b0100, 1);
    add(4'b0100, 32'hA,    1, 1, 32'hA,    4'b0100, 4'b0100, 1);
    add(4'b0100, 32'hB,    1, 1, 32'hB,    4'b0100, 4'b0100, 1);
    add(4'b0100, 32'hC,    1, 1, 32'hC,    4'b0100, 4'b0100, 1);
    add(4'b0000, 32'h0,    1, 0, 32'h0,    4'b0000, 4'b0000, 0);
    add(4'b0100, 32'h0202, 0, 0, 32'h0,    4'b0000, 4'b0000, 0);
    add(4'b0100, 32'h0202, 1, 1, 32'h0202, 4'b0100, 4'b0100, 1);
    add(4'b0100, 32'h4,    0, 1, 32'h4,    4'b0000, 4'b0100, 1);
    add(4'b0100, 32'h4,    1, 1, 32'h4,    4'b0100, 4'b0100, 1);
    for (int p = 1; p <= 4; p++) begin
      add(4'b0100, FW'(32'h50 + p), 0, 1, FW'(32'h50 + p), 4'b0000, 4'b0100, 1);
      add(4'b0100, FW'(32'h50 + p), 1, 1, FW'(32'h50 + p), 4'b0100, 4'b0100, 1);
    end
    add(4'b0000, 32'h0,    1, 0, 32'h0,    4'b0000, 4'b0000, 0);

    do_reset();
    rxrun = 0; bp_x = 0;
    for (int i = 0; i < tv.size(); i++) begin
      src_rx = tv[i].rx;
      credit = tv[i].cr;
      for (int s = 0; s < NSRC; s++) src_data[s] = (s == 2) ? tv[i].d : (32'hBAD0_0000 | 32'(s));
      @(negedge clk);
      check($sformatf("vec%0d", i), {rx_w, grant, src_credit, busy, data_w},
            {tv[i].erx, tv[i].eg, tv[i].ecr, tv[i].eb, tv[i].ed});
      if (i < 7 && rx_w) rxrun++;
      if (i >= 7 && rx_w && credit) bp_x++;
      @(posedge clk);
      #1;
    end
    check("single_rx_cycles", rxrun, 5);
    check("bp_transfers", bp_x, 6);

    // Round robin: all sources hold two size-1 packets from reset.
    do_reset();
    for (int r = 0; r < 2; r++) for (int s = 0; s < NSRC; s++) push_pkt(s, 1);
    run_drain("rr", 200);
    check("rr_ngrants", grants.size(), 8);
    for (int k = 0; k < grants.size() && k < 8; k++) check($sformatf("rr_grant%0d", k), grants[k], k % NSRC);
    check("rr_flits", got_cnt, 24);
    check("rr_stalls", busy_norx, 0);

    // Zero size packet, then a packet whose source drops rx for 3 cycles mid-payload.
    do_reset();
    push_pkt(0, 0);
    push_pkt(1, 4);
    gap_after[1] = 4;
    gap_len[1]   = 3;
    run_drain("zg", 100);
    check("zg_flits", got_cnt, 8);
    check("zg_gap_cycles", busy_norx, 3);
    check("zg_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("zg_grant0", grants[0], 0);
      check("zg_grant1", grants[1], 1);
    end

    // Asynchronous reset in the middle of a size-5 packet from src 1.
    do_reset();
    push_pkt(1, 5);
    n = 0;
    while (sent[1] < 4 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_reach_payload", 64'(sent[1]), 64'd4);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {rx_w, grant, src_credit, busy, data_w}, 64'h0);
    do_reset();
    push_pkt(1, 0);
    push_pkt(3, 0);
    run_drain("rst", 100);
    check("rst_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("rst_grant0", grants[0], 1);
      check("rst_grant1", grants[1], 3);
    end

    // Non-preemption: src 3 arrives while src 0 is mid-payload.
    do_reset();
    push_pkt(0, 3);
    n = 0;
    while (sent[0] < 3 && n < 20) begin
      cycle();
      n++;
    end
    push_pkt(3, 1);
    run_drain("np", 100);
    check("np_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("np_grant0", grants[0], 0);
      check("np_grant1", grants[1], 3);
    end
    check("np_grant_delay", first3_cyc - last0_cyc, 2);

    // Randomized traffic with random credit and source rx drops.
    do_reset();
    cred_mode = 1;
    drop_pct  = 20;
    total     = 0;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NSRC; s++) begin
        n = int'($urandom_range(2));
        for (int p = 0; p < n; p++) begin
          sz = int'($urandom_range(5));
          push_pkt(s, sz);
          total += sz + 2;
        end
      end
      run_drain($sformatf("rand%0d", r), 3000);
    end
    check("rand_flits", got_cnt, total);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
